fetch_stage: RTL and testbench

//  IF stage of the 5-stage MIPS pipeline; the decode stage consumes its D register.

---
 rtl/fetch_stage.sv | 119 +++++++++++
 tb/tb_fetch_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : IF stage of the 5-stage MIPS pipeline. Owns the PC, issues one
//            instruction request at a time, buffers a word across decode
//            stalls and applies delay-slot-correct redirects.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        D_st,
    input  logic        ifj,
    input  logic [31:0] pc_decode,
    output logic        ireq_valid,
    output logic [31:0] ireq_addr,
    input  logic        iresp_ok,
    input  logic [31:0] iresp_data,
    output logic        D_valid,
    output logic [31:0] D_pc,
    output logic [31:0] D_imp,
    output logic        D_adel
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_buf;
    logic [31:0] r_redir_pc;
    logic        r_redir_v;
    logic        r_d_valid;
    logic [31:0] r_d_pc;
    logic [31:0] r_d_imp;
    logic        r_d_adel;

    logic        w_misalign;
    logic        w_ifj_now;
    logic        w_fetch_done;
    logic        w_handoff;
    logic [31:0] w_word;
    logic [31:0] w_hand_word;
    logic [31:0] w_tgt;

    // A misaligned PC never reaches the bus; it completes at once with word 0.
    assign w_misalign   = (r_pc[1:0] != 2'b00);
    assign w_ifj_now    = ifj & ~D_st;
    assign w_fetch_done = (r_state == S_FETCH) & (w_misalign | iresp_ok);
    assign w_word       = w_misalign ? 32'h0000_0000 : iresp_data;
    assign w_handoff    = ~D_st & (w_fetch_done | (r_state == S_HOLD));
    assign w_hand_word  = (r_state == S_HOLD) ? r_buf : w_word;
    assign w_tgt        = w_ifj_now ? pc_decode :
                          (r_redir_v ? r_redir_pc : r_pc + 32'd4);

    assign ireq_valid = (r_state == S_FETCH) & ~w_misalign;
    assign ireq_addr  = r_pc;
    assign D_valid    = r_d_valid;
    assign D_pc       = r_d_pc;
    assign D_imp      = r_d_imp;
    assign D_adel     = r_d_adel;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = S_FETCH;
            S_FETCH: if (w_fetch_done) w_state_nxt = D_st ? S_HOLD : S_FETCH;
            S_HOLD:  if (!D_st) w_state_nxt = S_FETCH;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_buf      <= 32'h0000_0000;
            r_redir_v  <= 1'b0;
            r_redir_pc <= 32'h0000_0000;
            r_d_valid  <= 1'b0;
            r_d_pc     <= 32'h0000_0000;
            r_d_imp    <= 32'h0000_0000;
            r_d_adel   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_fetch_done && D_st) begin
                r_buf <= w_word;
            end
            if (w_handoff) begin
                r_pc      <= w_tgt;
                r_redir_v <= 1'b0;
                r_d_valid <= 1'b1;
                r_d_pc    <= r_pc;
                r_d_imp   <= w_hand_word;
                r_d_adel  <= w_misalign;
            end else begin
                // Delay slot still pending: remember the target until it hands off.
                if (w_ifj_now) begin
                    r_redir_v  <= 1'b1;
                    r_redir_pc <= pc_decode;
                end
                if (!D_st) begin
                    r_d_valid <= 1'b0;
                    r_d_pc    <= r_pc;
                    r_d_imp   <= 32'h0000_0000;
                    r_d_adel  <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Scoreboard bench for fetch_stage with a zero-wait instruction bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        D_st;
    logic        ifj;
    logic [31:0] pc_decode;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        iresp_ok;
    logic [31:0] iresp_data;
    logic        D_valid;
    logic [31:0] D_pc;
    logic [31:0] D_imp;
    logic        D_adel;
    logic        bus_en;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imp;
        logic        adel;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   prev_load = 1'b0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .D_st       (D_st),
        .ifj        (ifj),
        .pc_decode  (pc_decode),
        .ireq_valid (ireq_valid),
        .ireq_addr  (ireq_addr),
        .iresp_ok   (iresp_ok),
        .iresp_data (iresp_data),
        .D_valid    (D_valid),
        .D_pc       (D_pc),
        .D_imp      (D_imp),
        .D_adel     (D_adel)
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return 32'h2401_0000 | {16'h0000, (a[15:0] >> 2) + 16'd1};
    endfunction

    // Zero-wait memory: answers every request in the cycle it is made.
    always_comb begin
        iresp_ok   = bus_en & ireq_valid;
        iresp_data = word_of(ireq_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] imp, input logic adel);
        exp_t e;
        e.pc   = pc;
        e.imp  = imp;
        e.adel = adel;
        q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        D_st      = 1'b0;
        ifj       = 1'b0;
        pc_decode = 32'h0;
        bus_en    = 1'b0;
        fork
            begin : monitor
                forever begin
                    @(negedge clk);
                    if (prev_load && D_valid) begin
                        if (q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_d: got pc %h, expected no instruction", D_pc);
                        end else begin
                            exp_t e;
                            e = q.pop_front();
                            chk("sb_pc", D_pc, e.pc);
                            chk("sb_imp", D_imp, e.imp);
                            chk("sb_adel", {31'h0, D_adel}, {31'h0, e.adel});
                        end
                    end
                    prev_load = ~D_st & ~reset;
                end
            end
            begin : stimulus
                // Reset held 3 cycles
                for (int i = 0; i < 3; i++) begin
                    step();
                    chk("rst_d_valid", {31'h0, D_valid}, 32'h0);
                    chk("rst_ireq_valid", {31'h0, ireq_valid}, 32'h0);
                    chk("rst_d_imp", D_imp, 32'h0);
                end
                reset = 1'b0;
                chk("idle_ireq_valid", {31'h0, ireq_valid}, 32'h0);

                // Back-to-back zero-wait fetch
                bus_en = 1'b1;
                push(32'hbfc0_0000, word_of(32'hbfc0_0000), 1'b0);
                push(32'hbfc0_0004, word_of(32'hbfc0_0004), 1'b0);
                push(32'hbfc0_0008, word_of(32'hbfc0_0008), 1'b0);
                push(32'hbfc0_000c, word_of(32'hbfc0_000c), 1'b0);
                step();
                chk("first_ireq_valid", {31'h0, ireq_valid}, 32'h1);
                chk("first_ireq_addr", ireq_addr, 32'hbfc0_0000);
                for (int i = 0; i < 3; i++) begin
                    step();
                    chk("b2b_d_valid", {31'h0, D_valid}, 32'h1);
                    chk("b2b_d_pc", D_pc, 32'hbfc0_0000 + 32'(i * 4));
                end

                // Decode stall with a response in flight
                D_st = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    step();
                    chk("hold_ireq_valid", {31'h0, ireq_valid}, 32'h0);
                    chk("hold_d_pc", D_pc, 32'hbfc0_0008);
                end
                D_st = 1'b0;
                step();
                chk("unhold_d_imp", D_imp, word_of(32'hbfc0_000c));
                chk("unhold_ireq_addr", ireq_addr, 32'hbfc0_0010);

                // Branch with delay slot still in flight
                push(32'hbfc0_0010, word_of(32'hbfc0_0010), 1'b0);
                push(32'hbfc0_0014, word_of(32'hbfc0_0014), 1'b0);
                step();
                ifj = 1'b1;
                pc_decode = 32'hbfc0_0100;
                bus_en = 1'b0;
                step();
                chk("slot_bubble", {31'h0, D_valid}, 32'h0);
                chk("slot_ireq_addr", ireq_addr, 32'hbfc0_0014);
                ifj = 1'b0;
                bus_en = 1'b1;
                step();
                chk("slot_d_pc", D_pc, 32'hbfc0_0014);
                chk("redir_ireq_addr", ireq_addr, 32'hbfc0_0100);

                // Jump resolved in the same cycle the delay slot hands off
                push(32'hbfc0_0100, word_of(32'hbfc0_0100), 1'b0);
                push(32'hbfc0_0104, word_of(32'hbfc0_0104), 1'b0);
                step();
                ifj = 1'b1;
                pc_decode = 32'hbfc0_0200;
                step();
                chk("direct_ireq_addr", ireq_addr, 32'hbfc0_0200);
                chk("direct_d_pc", D_pc, 32'hbfc0_0104);

                // Jump during a decode stall is ignored
                D_st = 1'b1;
                pc_decode = 32'hbfc0_0300;
                bus_en = 1'b0;
                step();
                ifj = 1'b0;
                D_st = 1'b0;
                bus_en = 1'b1;
                push(32'hbfc0_0200, word_of(32'hbfc0_0200), 1'b0);
                step();
                chk("stall_ifj_ignored", ireq_addr, 32'hbfc0_0204);

                // Redirect to a misaligned address
                push(32'hbfc0_0204, word_of(32'hbfc0_0204), 1'b0);
                push(32'hbfc0_0102, 32'h0, 1'b1);
                push(32'hbfc0_0106, 32'h0, 1'b1);
                ifj = 1'b1;
                pc_decode = 32'hbfc0_0102;
                step();
                ifj = 1'b0;
                chk("adel_no_req", {31'h0, ireq_valid}, 32'h0);
                step();
                chk("adel_flag", {31'h0, D_adel}, 32'h1);
                chk("adel_imp", D_imp, 32'h0);
                chk("adel_pc", D_pc, 32'hbfc0_0102);
                ifj = 1'b1;
                pc_decode = 32'hbfc0_0400;
                step();
                ifj = 1'b0;
                chk("realign_ireq_valid", {31'h0, ireq_valid}, 32'h1);
                chk("realign_ireq_addr", ireq_addr, 32'hbfc0_0400);

                // Reset in the middle of a fetch
                bus_en = 1'b0;
                reset = 1'b1;
                step();
                chk("midrst_d_valid", {31'h0, D_valid}, 32'h0);
                chk("midrst_d_pc", D_pc, 32'h0);
                chk("midrst_d_imp", D_imp, 32'h0);
                chk("midrst_d_adel", {31'h0, D_adel}, 32'h0);
                chk("midrst_ireq_valid", {31'h0, ireq_valid}, 32'h0);
                reset = 1'b0;
                step();
                chk("postrst_ireq_valid", {31'h0, ireq_valid}, 32'h1);
                chk("postrst_ireq_addr", ireq_addr, 32'hbfc0_0000);
                step();
                step();
                chk("queue_empty", 32'(q.size()), 32'h0);
            end
        join_any
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
